// File: rtl/playfield_renderer.sv
// Scans the playfield bitmap column-major, overlays snapshotted sprites and streams one pixel write per cycle.
// Optional FRAME_BORDER_EN appends a WALL_COLOUR rectangle around the field before done.
module playfield_renderer #(
  parameter int                  FIELD_W     = 120,
  parameter int                  FIELD_H     = 100,
  parameter int                  ORG_X       = 20,
  parameter int                  ORG_Y       = 10,
  parameter int                  NUM_SPR     = 2,
  parameter int                  SPR_W       = 4,
  parameter int                  SPR_H       = 6,
  parameter int                  COORD_W     = 8,
  parameter int                  COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0] WALL_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
  parameter int                  AW          = 14
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [AW-1:0]               mem_addr,
  input  logic                        mem_rd_data,
  input  logic [NUM_SPR-1:0]          spr_valid,
  input  logic [NUM_SPR*COORD_W-1:0]  spr_x,
  input  logic [NUM_SPR*COORD_W-1:0]  spr_y,
  input  logic [NUM_SPR*COLOUR_W-1:0] spr_colour,
  output logic [COORD_W-1:0]          x,
  output logic [COORD_W-1:0]          y,
  output logic [COLOUR_W-1:0]         colour,
  output logic                        plot
);
  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
`ifdef FRAME_BORDER_EN
    BORDER,
`endif
    FINISH
  } state_t;

  localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(FIELD_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(FIELD_H - 1);
  localparam logic [COORD_W:0]   SPR_W_EXT = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0]   SPR_H_EXT = (COORD_W+1)'(SPR_H);

  state_t                      state_q, state_d;
  logic [COORD_W-1:0]          col_q, col_d, row_q, row_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic                        drain_q, drain_d;
  logic                        p1_vld_q, p1_vld_d;
  logic [COORD_W-1:0]          p1_col_q, p1_col_d, p1_row_q, p1_row_d;
  logic [NUM_SPR-1:0]          spr_valid_q, spr_valid_d;
  logic [NUM_SPR*COORD_W-1:0]  spr_x_q, spr_x_d, spr_y_q, spr_y_d;
  logic [NUM_SPR*COLOUR_W-1:0] spr_colour_q, spr_colour_d;
  logic                        plot_q, plot_d;
  logic [COORD_W-1:0]          x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0]         colour_q, colour_d;
  logic [NUM_SPR-1:0]          hit;
  logic [COLOUR_W-1:0]         pix_colour;

  // One extra bit on every bound so a sprite near the coordinate limit cannot wrap onto column/row 0.
  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_hit
    logic [COORD_W:0] sx, sy, c, r;
    assign sx = {1'b0, spr_x_q[gi*COORD_W +: COORD_W]};
    assign sy = {1'b0, spr_y_q[gi*COORD_W +: COORD_W]};
    assign c  = {1'b0, p1_col_q};
    assign r  = {1'b0, p1_row_q};
    assign hit[gi] = spr_valid_q[gi] && (c >= sx) && (c < sx + SPR_W_EXT)
                     && (r >= sy) && (r < sy + SPR_H_EXT);
  end

  always_comb begin
    pix_colour = mem_rd_data ? WALL_COLOUR : BG_COLOUR;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      if (hit[k]) pix_colour = spr_colour_q[k*COLOUR_W +: COLOUR_W];
    end
  end

`ifdef FRAME_BORDER_EN
  localparam int BORDER_N = 2 * (FIELD_W + 2) + 2 * FIELD_H;
  localparam int BIW      = $clog2(BORDER_N + 1);

  logic [BIW-1:0]     bidx_q, bidx_d;
  logic [COORD_W-1:0] bx, by;

  // Border order: top row, bottom row, left column, right column.
  always_comb begin : border_pos
    int bi;
    bi = int'(bidx_q);
    if (bi < FIELD_W + 2) begin
      bx = COORD_W'(ORG_X - 1 + bi);
      by = COORD_W'(ORG_Y - 1);
    end else if (bi < 2 * (FIELD_W + 2)) begin
      bx = COORD_W'(ORG_X - 1 + bi - (FIELD_W + 2));
      by = COORD_W'(ORG_Y + FIELD_H);
    end else if (bi < 2 * (FIELD_W + 2) + FIELD_H) begin
      bx = COORD_W'(ORG_X - 1);
      by = COORD_W'(ORG_Y + bi - 2 * (FIELD_W + 2));
    end else begin
      bx = COORD_W'(ORG_X + FIELD_W);
      by = COORD_W'(ORG_Y + bi - 2 * (FIELD_W + 2) - FIELD_H);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    spr_valid_d  = spr_valid_q;
    spr_x_d      = spr_x_q;
    spr_y_d      = spr_y_q;
    spr_colour_d = spr_colour_q;
    p1_vld_d     = 1'b0;
    p1_col_d     = col_q;
    p1_row_d     = row_q;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
`ifdef FRAME_BORDER_EN
    bidx_d       = bidx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          col_d        = '0;
          row_d        = '0;
          addr_d       = '0;
          spr_valid_d  = spr_valid;
          spr_x_d      = spr_x;
          spr_y_d      = spr_y;
          spr_colour_d = spr_colour;
`ifdef FRAME_BORDER_EN
          bidx_d       = '0;
`endif
        end
      end
      SCAN: begin
        // Column-major scan means the address is a plain running count.
        p1_vld_d = 1'b1;
        addr_d   = addr_q + AW'(1);
        if (row_q == ROW_LAST) begin
          row_d = '0;
          col_d = col_q + COORD_W'(1);
          if (col_q == COL_LAST) begin
            state_d = DRAIN;
            drain_d = 1'b0;
            addr_d  = '0;
          end
        end else begin
          row_d = row_q + COORD_W'(1);
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
`ifdef FRAME_BORDER_EN
          state_d = BORDER;
`else
          state_d = FINISH;
`endif
        end
      end
`ifdef FRAME_BORDER_EN
      BORDER: begin
        if (bidx_q == BIW'(BORDER_N)) state_d = FINISH;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (p1_vld_q) begin
      plot_d   = 1'b1;
      x_d      = COORD_W'(ORG_X) + p1_col_q;
      y_d      = COORD_W'(ORG_Y) + p1_row_q;
      colour_d = pix_colour;
    end
`ifdef FRAME_BORDER_EN
    // Loading on entry to BORDER lets the first border plot follow the last field plot directly.
    if (state_d == BORDER) begin
      plot_d   = 1'b1;
      x_d      = bx;
      y_d      = by;
      colour_d = WALL_COLOUR;
      bidx_d   = bidx_q + BIW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      drain_q      <= 1'b0;
      p1_vld_q     <= 1'b0;
      p1_col_q     <= '0;
      p1_row_q     <= '0;
      spr_valid_q  <= '0;
      spr_x_q      <= '0;
      spr_y_q      <= '0;
      spr_colour_q <= '0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
`ifdef FRAME_BORDER_EN
      bidx_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      drain_q      <= drain_d;
      p1_vld_q     <= p1_vld_d;
      p1_col_q     <= p1_col_d;
      p1_row_q     <= p1_row_d;
      spr_valid_q  <= spr_valid_d;
      spr_x_q      <= spr_x_d;
      spr_y_q      <= spr_y_d;
      spr_colour_q <= spr_colour_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
`ifdef FRAME_BORDER_EN
      bidx_q       <= bidx_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);
  assign mem_rd_en = (state_q == SCAN);
  assign mem_addr  = addr_q;
  assign plot      = plot_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
endmodule

// File: tb/tb_playfield_renderer.sv
// Randomised frame-level bench for playfield_renderer on a 4x3 field with a scoreboard built from pixel rules.
module tb_playfield_renderer;
  localparam int FW = 4, FH = 3, OX = 20, OY = 10, NS = 2, SW = 2, SH = 2;
  localparam int CW = 8, COLW = 3, AWB = 4;
  localparam int P = FW * FH;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, mem_rd_en, plot;
  logic [AWB-1:0]    mem_addr;
  logic              mem_rd_data = 1'b0;
  logic [NS-1:0]     spr_valid = '0;
  logic [NS*CW-1:0]  spr_x = '0, spr_y = '0;
  logic [NS*COLW-1:0] spr_colour = '0;
  logic [CW-1:0]     x, y;
  logic [COLW-1:0]   colour;

  playfield_renderer #(
    .FIELD_W(FW), .FIELD_H(FH), .ORG_X(OX), .ORG_Y(OY), .NUM_SPR(NS),
    .SPR_W(SW), .SPR_H(SH), .COORD_W(CW), .COLOUR_W(COLW),
    .WALL_COLOUR(3'b111), .BG_COLOUR(3'b000), .AW(AWB)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .spr_valid(spr_valid), .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  bit ram [0:15];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sv[NS], sx[NS], sy[NS], sc[NS];
  int ex[$], ey[$], ec[$], ea[$];
  int got_x[64], got_y[64], got_c[64];
  int T, t0, nplots;
  bit frame_on = 1'b0, chk_en = 1'b0;
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected frame: every field pixel in column-major order, then the border rectangle if built in.
  function automatic void build_expected();
    ex.delete(); ey.delete(); ec.delete(); ea.delete();
    for (int c = 0; c < FW; c++) begin
      for (int r = 0; r < FH; r++) begin
        int col;
        col = ram[c*FH + r] ? 7 : 0;
        for (int k = NS - 1; k >= 0; k--)
          if (sv[k] != 0 && c >= sx[k] && c < sx[k] + SW && r >= sy[k] && r < sy[k] + SH)
            col = sc[k];
        ea.push_back(c*FH + r);
        ex.push_back(OX + c); ey.push_back(OY + r); ec.push_back(col);
      end
    end
`ifdef FRAME_BORDER_EN
    for (int xx = OX - 1; xx <= OX + FW; xx++) begin ex.push_back(xx); ey.push_back(OY - 1); ec.push_back(7); end
    for (int xx = OX - 1; xx <= OX + FW; xx++) begin ex.push_back(xx); ey.push_back(OY + FH); ec.push_back(7); end
    for (int yy = OY; yy < OY + FH; yy++) begin ex.push_back(OX - 1); ey.push_back(yy); ec.push_back(7); end
    for (int yy = OY; yy < OY + FH; yy++) begin ex.push_back(OX + FW); ey.push_back(yy); ec.push_back(7); end
`endif
  endfunction

  always @(negedge clk) begin : cmp
    int d;
    if (chk_en) begin
      if (!frame_on) begin
        chk("idle_plot", int'(plot), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_rd_en", int'(mem_rd_en), 0);
      end else begin
        d = cyc - t0;
        chk("busy", int'(busy), int'(d >= 0 && d < 2 + T));
        chk("done", int'(done), int'(d == 2 + T));
        chk("plot", int'(plot), int'(d >= 2 && d < 2 + T));
        chk("rd_en", int'(mem_rd_en), int'(d >= 0 && d < P));
        if (d >= 0 && d < P) chk("addr", int'(mem_addr), ea[d]);
        if (plot) nplots++;
        if (d >= 2 && d < 2 + T) begin
          got_x[d-2] = int'(x); got_y[d-2] = int'(y); got_c[d-2] = int'(colour);
          chk("x", int'(x), ex[d-2]);
          chk("y", int'(y), ey[d-2]);
          chk("colour", int'(colour), ec[d-2]);
        end
      end
    end
  end

  task automatic apply_spr();
    for (int k = 0; k < NS; k++) begin
      spr_valid[k]              = (sv[k] != 0);
      spr_x[k*CW +: CW]         = CW'(sx[k]);
      spr_y[k*CW +: CW]         = CW'(sy[k]);
      spr_colour[k*COLW +: COLW] = COLW'(sc[k]);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 16; i++) ram[i] = 1'b0;
    for (int k = 0; k < NS; k++) begin sv[k] = 0; sx[k] = 0; sy[k] = 0; sc[k] = 0; end
  endtask

  // mid_start: -1 random re-pulse, 0 none, else cycle offset; abort_at > 0 resets the DUT at that offset.
  task automatic run_frame(input int mid_start, input int abort_at);
    int ms;
    build_expected();
    T = ex.size();
    nplots = 0;
    ms = (mid_start < 0) ? int'($urandom_range(1, 2 + T)) : mid_start;
    apply_spr();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    frame_on = 1'b1;
    spr_valid  = NS'($urandom);
    spr_x      = (NS*CW)'($urandom);
    spr_y      = (NS*CW)'($urandom);
    spr_colour = (NS*COLW)'($urandom);
    for (int d = 1; d <= 3 + T; d++) begin
      @(posedge clk); #1;
      start = (d == ms);
      if (d == abort_at) begin
        @(negedge clk); #1;
        resetn = 1'b0; chk_en = 1'b0; frame_on = 1'b0; start = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x", int'(x), 0);
        chk_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        return;
      end
    end
    start = 1'b0;
    frame_on = 1'b0;
    chk("plot_count", nplots, T);
  endtask

  initial begin
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_addr", int'(mem_addr), 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    clear_all();
    run_frame(0, 0);
    chk("A_first_x", got_x[0], 20);
    chk("A_first_y", got_y[0], 10);
    chk("A_last_x", got_x[11], 23);
    chk("A_last_y", got_y[11], 12);
    chk("A_colour", got_c[5], 0);
`ifdef FRAME_BORDER_EN
    chk("border_total", nplots, 30);
    chk("border_first_x", got_x[P], 19);
    chk("border_first_y", got_y[P], 9);
    chk("border_last_x", got_x[P+17], 24);
    chk("border_last_y", got_y[P+17], 12);
`endif

    clear_all(); ram[7] = 1'b1;
    run_frame(0, 0);
    chk("B_wall_x", got_x[7], 22);
    chk("B_wall_y", got_y[7], 11);
    chk("B_wall_colour", got_c[7], 7);
    chk("B_bg_colour", got_c[6], 0);

    clear_all();
    for (int i = 0; i < P; i++) ram[i] = 1'b1;
    sv[0] = 1; sx[0] = 1; sy[0] = 1; sc[0] = 4;
    run_frame(0, 0);
    chk("C_spr_21_11", got_c[4], 4);
    chk("C_spr_22_12", got_c[8], 4);
    chk("C_wall_20_10", got_c[0], 7);

    clear_all();
    sv[0] = 1; sx[0] = 3; sy[0] = 2; sc[0] = 4;
    sv[1] = 1; sx[1] = 3; sy[1] = 2; sc[1] = 2;
    run_frame(0, 0);
    chk("D_prio_23_12", got_c[11], 4);
    chk("D_bg_23_11", got_c[10], 0);

    clear_all();
    sv[0] = 1; sx[0] = 255; sy[0] = 0; sc[0] = 4;
    run_frame(0, 0);
    chk("E_nowrap", got_c[0], 0);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 16; i++) ram[i] = 1'($urandom);
      for (int k = 0; k < NS; k++) begin
        sv[k] = int'($urandom_range(0, 1));
        sx[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 5));
        sy[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 4));
        sc[k] = int'($urandom_range(0, 7));
      end
      run_frame(-1, 0);
    end

    run_frame(3, 7);
    run_frame(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/playfield_renderer.md
Name: playfield_renderer

Overview:
Parametrised successor to the wall/dude screen updater. On each `start` it scans a FIELD_W x FIELD_H playfield bitmap held in external synchronous RAM, one pixel per clock. It overlays up to NUM_SPR rectangular sprites and emits one pixel write per cycle (x, y, colour, plot) to the vga_adapter. It sits between the game datapath (bitmap RAM and sprite positions) and the VGA adapter, and replaces the display-phase sequencer; `done` is the handshake back to control.

Parameters:
FIELD_W, 120, playfield columns
FIELD_H, 100, playfield rows
ORG_X, 20, screen x of field column 0 (must be >=1)
ORG_Y, 10, screen y of field row 0 (must be >=1)
NUM_SPR, 2, number of sprites (1..4)
SPR_W, 4, sprite width in pixels
SPR_H, 6, sprite height in pixels
COORD_W, 8, width of all coordinates
COLOUR_W, 3, colour width
WALL_COLOUR, 3'b111, colour of a set bitmap bit
BG_COLOUR, 3'b000, colour of a clear bitmap bit
AW, 14, RAM address width (must satisfy 2^AW >= FIELD_W*FIELD_H)

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
start  in  1  begin a frame; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the final pixel has been plotted
mem_rd_en  out  1  RAM read strobe
mem_addr  out  AW  address = col*FIELD_H + row
mem_rd_data  in  1  bitmap bit, valid 1 cycle after mem_rd_en
spr_valid  in  NUM_SPR  per-sprite enable
spr_x  in  NUM_SPR*COORD_W  sprite left column, field coordinates
spr_y  in  NUM_SPR*COORD_W  sprite top row, field coordinates
spr_colour  in  NUM_SPR*COLOUR_W  sprite colours
x  out  COORD_W  screen x
y  out  COORD_W  screen y
colour  out  COLOUR_W  pixel colour
plot  out  1  pixel write strobe

Behaviour:
- Reset: state IDLE; busy=0, done=0, plot=0, mem_rd_en=0, x=0, y=0, colour=0, mem_addr=0. Reset mid-frame aborts immediately; no done pulse.
- States: IDLE -> SCAN -> DRAIN -> (BORDER, when the optional feature is compiled in) -> FINISH -> IDLE.
- IDLE: on start=1, snapshot spr_valid/spr_x/spr_y/spr_colour into internal registers, clear col/row, go to SCAN. A start asserted in any other state is ignored.
- SCAN: each cycle mem_rd_en=1 and mem_addr=col*FIELD_H+row.
  - Row increments first (column-major order); at row=FIELD_H-1 row wraps to 0 and col increments.
  - After issuing the address (FIELD_W-1, FIELD_H-1), go to DRAIN.
- Pipeline: stage 1 issues the address and delays col/row. Stage 2 registers the outputs: plot=1, x=ORG_X+col, y=ORG_Y+row, colour computed as below.
  - Address-to-plot latency is 2 cycles.
  - Exactly FIELD_W*FIELD_H plots per frame, on consecutive cycles with no gaps.
- Colour select: sprite k hits when spr_valid[k], spr_x[k] <= col < spr_x[k]+SPR_W, and spr_y[k] <= row < spr_y[k]+SPR_H.
  - Compare in COORD_W+1 bits so no wrap-around occurs.
  - The lowest-index hitting sprite wins. With no hit, colour = mem_rd_data ? WALL_COLOUR : BG_COLOUR.
  - Sprite pixels outside the field are clipped and never plotted.
- DRAIN: 2 cycles while the pipeline empties; mem_rd_en=0.
- FINISH: done=1 for 1 cycle, busy drops the same cycle, plot=0; return to IDLE.
- Sprite inputs may change during a frame without effect; only the snapshot is used.
- busy=1 from the cycle after start is sampled through the last plot.

Optional Feature:
Macro FRAME_BORDER_EN.
- Defined: after DRAIN, state BORDER plots a 1-pixel rectangle of WALL_COLOUR around the field, one plot per cycle, then FINISH. Order:
  - top row y=ORG_Y-1, x=ORG_X-1..ORG_X+FIELD_W;
  - bottom row y=ORG_Y+FIELD_H, same x range;
  - left column x=ORG_X-1, y=ORG_Y..ORG_Y+FIELD_H-1;
  - right column x=ORG_X+FIELD_W, same y range.
  - This adds 2*(FIELD_W+2)+2*FIELD_H plots.
- Undefined: BORDER does not exist; DRAIN goes directly to FINISH.

Test Plan:
- FIELD_W=4, FIELD_H=3, ORG=(20,10), all-zero RAM, no sprites, start pulse -> 12 consecutive plots starting 3 cycles after start, with (x,y) = (20,10),(20,11),(20,12),(21,10)...(23,12), all colour 000; one done pulse; busy low afterwards.
- Same config, RAM bit at addr 7 = 1 -> the plot at (22,11) has colour 111; all others 000.
- Sprite 0 valid at (1,1), colour 100, SPR_W=2, SPR_H=2, RAM all ones -> (21,11),(21,12),(22,11),(22,12) are 100; the other 8 plots are 111.
- Sprite 0 at (3,2) colour 100 and sprite 1 at (3,2) colour 010, both valid -> only (23,12) is 100 (clipped overlap, priority to sprite 0); no plot outside the 4x3 area.
- Start re-pulsed mid-frame, then resetn=0 at plot 5 -> exactly one frame in progress; after reset, plot=0, busy=0, and no done pulse.
- FRAME_BORDER_EN defined, 4x3 field -> 12 field plots followed by 18 border plots, the first at (19,9) and the last at (24,12); done pulses after the 30th plot.
